// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signal bundle for the branch predictor.
// The master side is the pipeline; the slave side is the predictor.
interface branch_predictor_if;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_branch_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output f_valid, f_pc,
    output ex_valid, ex_is_branch, ex_pc, ex_pred_taken, ex_pred_target,
    output ex_branch_taken, ex_target,
    input  pred_taken, pred_target, redirect_valid, redirect_pc,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  f_valid, f_pc,
    input  ex_valid, ex_is_branch, ex_pc, ex_pred_taken, ex_pred_target,
    input  ex_branch_taken, ex_target,
    output pred_taken, pred_target, redirect_valid, redirect_pc,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch lookup,
// execute-stage training, registered mispredict redirect and statistics counters.
module branch_predictor #(
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [1:0]    cnt_q    [ENTRIES];

  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] branch_count_q, mispredict_count_q;

  logic [IW-1:0] f_idx, ex_idx;
  logic [TW-1:0] f_tag, ex_tag;
  logic          update, mispredict;
  logic [1:0]    cnt_cur, cnt_d;
  logic          unused_pc_bits;

  assign f_idx  = bp.f_pc[IW+1:2];
  assign f_tag  = bp.f_pc[31:IW+2];
  assign ex_idx = bp.ex_pc[IW+1:2];
  assign ex_tag = bp.ex_pc[31:IW+2];
  assign unused_pc_bits = ^{bp.f_pc[1:0], bp.ex_pc[1:0]};

  // Lookup sees only pre-edge state; a same-cycle write to this index is not forwarded.
  assign bp.pred_taken  = bp.f_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag) & cnt_q[f_idx][1];
  assign bp.pred_target = bp.pred_taken ? target_q[f_idx] : bp.f_pc + 32'd4;

  assign update     = bp.ex_valid & bp.ex_is_branch;
  assign mispredict = (bp.ex_branch_taken != bp.ex_pred_taken) |
                      (bp.ex_branch_taken & bp.ex_pred_taken &
                       (bp.ex_pred_target != bp.ex_target));

  assign cnt_cur = cnt_q[ex_idx];

  always_comb begin
    cnt_d = cnt_cur;
    if (bp.ex_branch_taken) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'b01;
    end
  end

  always_comb begin
    redirect_valid_d = update & mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (update & mispredict)
      redirect_pc_d = bp.ex_branch_taken ? bp.ex_target : bp.ex_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_INIT;
      end
    end else if (update) begin
      cnt_q[ex_idx] <= cnt_d;
      // Taken outcomes claim the entry outright; not-taken only trains the counter.
      if (bp.ex_branch_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= bp.ex_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      if (update) branch_count_q <= branch_count_q + 32'd1;
      if (update & mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign bp.redirect_valid   = redirect_valid_q;
  assign bp.redirect_pc      = redirect_pc_q;
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(64), .CNT_INIT(2'b01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                     input logic pred, input logic [31:0] ptarget);
    @(negedge clk);
    bp.ex_valid        = 1'b1;
    bp.ex_is_branch    = 1'b1;
    bp.ex_pc           = pc;
    bp.ex_branch_taken = taken;
    bp.ex_target       = target;
    bp.ex_pred_taken   = pred;
    bp.ex_pred_target  = ptarget;
    @(posedge clk);
    #1;
    bp.ex_valid = 1'b0;
    $display("upd pc=%h taken=%0d target=%h pred=%0d ptarget=%h -> redir=%0d rpc=%h br=%0d mis=%0d",
             pc, taken, target, pred, ptarget, bp.redirect_valid, bp.redirect_pc,
             bp.branch_count, bp.mispredict_count);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [31:0] exp_target);
    bp.f_valid = 1'b1;
    bp.f_pc    = pc;
    #1;
    $display("look pc=%h -> taken=%0d target=%h", pc, bp.pred_taken, bp.pred_target);
    check_eq({tag, "_taken"}, {31'd0, bp.pred_taken}, {31'd0, exp_taken});
    check_eq({tag, "_target"}, bp.pred_target, exp_target);
  endtask

  task automatic chk_redir(input string tag, input logic v, input logic [31:0] pc);
    check_eq({tag, "_rv"}, {31'd0, bp.redirect_valid}, {31'd0, v});
    if (v) check_eq({tag, "_rpc"}, bp.redirect_pc, pc);
  endtask

  task automatic chk_counts(input string tag, input int br, input int mis);
    check_eq({tag, "_br"}, bp.branch_count, br);
    check_eq({tag, "_mis"}, bp.mispredict_count, mis);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bp.f_valid = 1'b0; bp.f_pc = '0;
    bp.ex_valid = 1'b0; bp.ex_is_branch = 1'b0; bp.ex_pc = '0;
    bp.ex_pred_taken = 1'b0; bp.ex_pred_target = '0;
    bp.ex_branch_taken = 1'b0; bp.ex_target = '0;

    // Reset state
    #12;
    chk_redir("rst", 1'b0, 32'd0);
    check_eq("rst_rpc", bp.redirect_pc, 32'd0);
    chk_counts("rst", 0, 0);
    look("rst_look", 32'h100, 1'b0, 32'h104);
    @(negedge clk);
    rst_n = 1'b1;

    // First taken update trains entry and redirects
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    chk_redir("t1", 1'b1, 32'h80);
    chk_counts("t1", 1, 1);
    look("t1_look", 32'h100, 1'b1, 32'h80);
    look("alias", 32'h200, 1'b0, 32'h204);
    @(posedge clk); #1;
    chk_redir("t1_clr", 1'b0, 32'h0);

    // Saturation at pc 0x40, back-to-back updates
    upd(32'h40, 1'b1, 32'h1000, 1'b0, 32'h0);
    chk_redir("s1", 1'b1, 32'h1000);
    upd(32'h40, 1'b1, 32'h1000, 1'b1, 32'h1000);
    chk_redir("s2", 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h1000, 1'b1, 32'h1000);
    upd(32'h40, 1'b1, 32'h1000, 1'b1, 32'h1000);
    chk_counts("s4", 5, 2);
    upd(32'h40, 1'b0, 32'h1000, 1'b1, 32'h1000);
    chk_redir("s5", 1'b1, 32'h44);
    chk_counts("s5", 6, 3);
    look("s5_look", 32'h40, 1'b1, 32'h1000);
    upd(32'h40, 1'b0, 32'h1000, 1'b1, 32'h1000);
    chk_redir("s6", 1'b1, 32'h44);
    chk_counts("s6", 7, 4);
    look("s6_look", 32'h40, 1'b0, 32'h44);

    // Correct direction, wrong target
    upd(32'h500, 1'b1, 32'h300, 1'b1, 32'h200);
    chk_redir("tgt", 1'b1, 32'h300);
    chk_counts("tgt", 8, 5);
    look("tgt_look", 32'h500, 1'b1, 32'h300);

    // Correctly predicted not-taken
    upd(32'h600, 1'b0, 32'h900, 1'b0, 32'h0);
    chk_redir("nt", 1'b0, 32'h0);
    chk_counts("nt", 9, 5);

    // Non-branch instruction must not update anything
    @(negedge clk);
    bp.ex_valid = 1'b1; bp.ex_is_branch = 1'b0; bp.ex_pc = 32'h700;
    bp.ex_branch_taken = 1'b1; bp.ex_target = 32'h40; bp.ex_pred_taken = 1'b0;
    @(posedge clk); #1;
    bp.ex_valid = 1'b0;
    chk_redir("nb", 1'b0, 32'h0);
    chk_counts("nb", 9, 5);
    look("nb_look", 32'h700, 1'b0, 32'h704);

    // Same-cycle write is not bypassed into the lookup
    @(negedge clk);
    bp.ex_valid = 1'b1; bp.ex_is_branch = 1'b1; bp.ex_pc = 32'h804;
    bp.ex_branch_taken = 1'b1; bp.ex_target = 32'h900;
    bp.ex_pred_taken = 1'b0; bp.ex_pred_target = 32'h0;
    look("byp_pre", 32'h804, 1'b0, 32'h808);
    @(posedge clk); #1;
    bp.ex_valid = 1'b0;
    look("byp_post", 32'h804, 1'b1, 32'h900);
    chk_redir("byp", 1'b1, 32'h900);
    chk_counts("byp", 10, 6);

    // PC wrap on not-taken redirect, then async reset mid-redirect
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234);
    chk_redir("wrap", 1'b1, 32'h0);
    check_eq("wrap_rpc", bp.redirect_pc, 32'h0);
    chk_counts("wrap", 11, 7);
    #1;
    rst_n = 1'b0;
    #1;
    chk_redir("arst", 1'b0, 32'h0);
    chk_counts("arst", 0, 0);
    look("arst_look", 32'h100, 1'b0, 32'h104);
    @(negedge clk);
    rst_n = 1'b1;
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    chk_redir("post", 1'b1, 32'h80);
    chk_counts("post", 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 64: number of BTB/BHT entries; power of two, 4 to 256.
REQ-002 Parameter CNT_INIT, default 2'b01: counter reset value, weakly not-taken.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 f_valid  input  1: fetch stage presents a PC for lookup.
REQ-006 f_pc  input  32: fetch PC.
REQ-007 pred_taken  output  1: fetch-stage prediction, combinational from f_pc.
REQ-008 pred_target  output  32: predicted target; f_pc+4 when pred_taken=0.
REQ-009 ex_valid  input  1: execute stage holds a valid instruction.
REQ-010 ex_is_branch  input  1: execute-stage instruction is a conditional branch.
REQ-011 ex_pc  input  32: PC of the execute-stage instruction.
REQ-012 ex_pred_taken  input  1: prediction carried down the pipe with that instruction.
REQ-013 ex_pred_target  input  32: predicted target carried down the pipe with that instruction.
REQ-014 ex_branch_taken  input  1: resolved outcome from the branch comparator.
REQ-015 ex_target  input  32: computed branch target (pc+imm).
REQ-016 redirect_valid  output  1: registered mispredict redirect pulse.
REQ-017 redirect_pc  output  32: correct fetch PC, valid while redirect_valid=1.
REQ-018 branch_count  output  32: resolved branches, wrapping.
REQ-019 mispredict_count  output  32: mispredicted branches, wrapping.

Function
REQ-020 Index = pc[IW+1:2] with IW=log2(ENTRIES); tag = pc[31:IW+2].
REQ-021 Each entry holds a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.
REQ-022 Counters are indexed without tag checking; the BTB valid/tag pair gates the taken prediction.
REQ-023 pred_taken = f_valid & valid[idx] & (tag[idx]==f_tag) & cnt[idx][1]; pred_target = stored target when pred_taken=1.
REQ-024 Lookup has zero latency and reads pre-edge state; there is no bypass when the same index is written in the same cycle.
REQ-025 An update occurs at the edge when ex_valid & ex_is_branch; no state changes otherwise.
REQ-026 Counter update: taken increments and saturates at 3; not-taken decrements and saturates at 0.
REQ-027 A taken update writes valid=1, the tag and ex_target, overwriting any prior occupant.
REQ-028 A not-taken update leaves the valid bit, tag and target unchanged.
REQ-029 mispredict = (ex_branch_taken != ex_pred_taken) | (ex_branch_taken & ex_pred_taken & ex_pred_target != ex_target).
REQ-030 On an update with mispredict, redirect_valid=1 for exactly the next cycle.
REQ-031 redirect_pc = ex_target if taken, else ex_pc+4 (mod 2^32).
REQ-032 Mispredicts in back-to-back cycles each produce a one-cycle redirect carrying its own redirect_pc.
REQ-033 branch_count increments by 1 per update; mispredict_count increments by 1 per mispredicting update; both wrap 0xFFFFFFFF->0.
REQ-034 The block never stalls and has no backpressure; updates are accepted in every cycle, including cycles with redirect_valid=1.

Reset
REQ-035 While rst_n=0: all valid bits=0, all counters=CNT_INIT, redirect_valid=0, redirect_pc=0, both counts=0.
REQ-036 Assertion of rst_n mid-redirect clears redirect_valid immediately and asynchronously; the first update is accepted at the first edge after deassertion.
REQ-037 After reset, pred_taken=0 for every PC until a taken update for that PC.

Verification
REQ-038 After reset, lookup f_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-039 Taken update pc=0x100, target=0x80, pred=0 -> next cycle redirect_valid=1, redirect_pc=0x80, mispredict_count=1, cnt=2; lookup 0x100 -> pred_taken=1, pred_target=0x80.
REQ-040 Four taken updates then one not-taken at pc=0x40 -> cnt saturates at 3 then drops to 2, prediction stays taken; the not-taken update with pred=1 redirects to 0x44.
REQ-041 Aliasing: taken update at pc 0x100 then lookup at pc 0x100+4*ENTRIES -> pred_taken=0 (tag miss).
REQ-042 Correctly predicted taken, with ex_pred_target 0x200 and ex_target 0x300 -> redirect to 0x300 and mispredict counted.
REQ-043 Update at pc 0xFFFFFFFC not-taken with pred=1 -> redirect_pc=0x00000000; rst_n pulled low during that redirect -> redirect_valid=0 immediately.
